// File: rtl/writeback_unit_if.sv
// Bundle of the writeback unit's result, issue and register-file write signals.
// The master side is the pipeline: it drives the ALU, LSU and issue sources.
// The slave side is the writeback unit.
//
// LSU handshake: lsu_valid is asserted by the producer while lsu_dest/lsu_data
// are stable. lsu_ready is asserted by the writeback unit when it can take a
// result. A transfer happens on every rising clk edge where both are high.
// After lsu_valid rises, the producer keeps it high until that transfer.
// lsu_ready depends only on the current buffer occupancy and never on lsu_valid.
interface writeback_unit_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_dest;
    logic [DATA_W-1:0]     alu_data;
    logic                  lsu_valid;
    logic                  lsu_ready;
    logic [REG_ADDR_W-1:0] lsu_dest;
    logic [DATA_W-1:0]     lsu_data;
    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_dest;
    logic [31:0]           busy_mask;
    logic [CNT_W-1:0]      fifo_count;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0]     write_data;

    modport master (
        output alu_valid, alu_dest, alu_data,
        output lsu_valid, lsu_dest, lsu_data,
        output issue_valid, issue_dest,
        input  lsu_ready, busy_mask, fifo_count,
        input  reg_write, write_reg, write_data
    );

    modport slave (
        input  alu_valid, alu_dest, alu_data,
        input  lsu_valid, lsu_dest, lsu_data,
        input  issue_valid, issue_dest,
        output lsu_ready, busy_mask, fifo_count,
        output reg_write, write_reg, write_data
    );
endinterface

// File: rtl/writeback_unit.sv
// Writeback unit: arbitrates the single register-file write port.
// ALU results have the highest priority. Long-latency LSU results are queued
// in a small FIFO and drain in arrival order whenever the ALU leaves the slot
// free. A busy scoreboard tracks registers that still wait for an LSU write.
module writeback_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    writeback_unit_if.slave   bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // FIFO storage and control
    logic [REG_ADDR_W-1:0] r_mem_dest [FIFO_DEPTH];
    logic [DATA_W-1:0]     r_mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    // Scoreboard and registered write port
    logic [31:0]           r_busy;
    logic                  r_reg_write;
    logic [REG_ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0]     r_write_data;

    logic                  w_alu_take;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic                  w_push;
    logic                  w_pop;
    logic [REG_ADDR_W-1:0] w_head_dest;
    logic [DATA_W-1:0]     w_head_data;
    logic                  w_head_write;
    logic [31:0]           w_busy_next;

    // An ALU result aimed at register 0 does not claim the write slot.
    assign w_alu_take   = bus.alu_valid && (bus.alu_dest != '0);
    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_full  = (r_count == CNT_W'(FIFO_DEPTH));
    // Acceptance uses the current occupancy only, so a pop in this cycle
    // does not free a slot until the next cycle.
    assign w_push       = bus.lsu_valid && !w_fifo_full;
    assign w_pop        = !w_fifo_empty && !w_alu_take;
    assign w_head_dest  = r_mem_dest[r_rd_ptr];
    assign w_head_data  = r_mem_data[r_rd_ptr];
    // A popped head that targets register 0 is dropped and does not write.
    assign w_head_write = w_pop && (w_head_dest != '0);

    // Next scoreboard value: the pop clears first, then the issue sets, so a set wins.
    always_comb begin
        w_busy_next = r_busy;
        if (w_head_write) begin
            w_busy_next[w_head_dest] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_dest != '0)) begin
            w_busy_next[bus.issue_dest] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    // FIFO entry storage. There is no reset here because the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_dest[r_wr_ptr] <= bus.lsu_dest;
            r_mem_data[r_wr_ptr] <= bus.lsu_data;
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered write port: the ALU first, then the FIFO head. The address and data are zero when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end else if (w_alu_take) begin
            r_reg_write  <= 1'b1;
            r_write_reg  <= bus.alu_dest;
            r_write_data <= bus.alu_data;
        end else if (w_head_write) begin
            r_reg_write  <= 1'b1;
            r_write_reg  <= w_head_dest;
            r_write_data <= w_head_data;
        end else begin
            r_reg_write  <= 1'b0;
            r_write_reg  <= '0;
            r_write_data <= '0;
        end
    end

    // Scoreboard register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign bus.lsu_ready  = !w_fifo_full;
    assign bus.fifo_count = r_count;
    assign bus.busy_mask  = r_busy;
    assign bus.reg_write  = r_reg_write;
    assign bus.write_reg  = r_write_reg;
    assign bus.write_data = r_write_data;

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Drives the write port of the 32x32 register file: reg_write, write_reg and write_data.
- Merges two result sources into at most one register write per cycle:
  - single-cycle ALU results, which are never stalled;
  - long-latency load/store-unit (LSU) results, which are buffered in a small FIFO.
- Keeps a busy scoreboard of destination registers with pending long-latency writes, so decode can stall on RAW hazards.

Parameters:
- DATA_W, 32, register data width.
- REG_ADDR_W, 5, register address width.
- FIFO_DEPTH, 4, LSU result buffer entries; power of two, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- alu_valid  input  1  ALU result present this cycle; always accepted.
- alu_dest  input  REG_ADDR_W  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- lsu_valid  input  1  LSU result offered.
- lsu_ready  output  1  FIFO can accept; a transfer occurs when lsu_valid && lsu_ready.
- lsu_dest  input  REG_ADDR_W  LSU destination register.
- lsu_data  input  DATA_W  LSU result.
- issue_valid  input  1  decode issued a long-latency op this cycle.
- issue_dest  input  REG_ADDR_W  destination register of the issued op.
- busy_mask  output  32  scoreboard; bit n = 1 means register n has a pending LSU write.
- fifo_count  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- reg_write  output  1  register file write enable (registered).
- write_reg  output  REG_ADDR_W  register file write address (registered).
- write_data  output  DATA_W  register file write data (registered).

Behaviour:
- Reset (synchronous, evaluated at clk edge):
  - reg_write=0, write_reg=0, write_data=0, busy_mask=0, fifo_count=0.
  - FIFO pointers cleared.
  - Reset mid-operation discards all buffered entries; no buffered entry is written afterwards.
- Write-port outputs are registered: a result selected in cycle N appears on reg_write/write_reg/write_data in cycle N+1, held for exactly one cycle.
- Arbitration each cycle, at most one write:
  - Priority 1: ALU, when alu_valid=1 and alu_dest!=0.
  - Priority 2: FIFO head, when the FIFO is non-empty and the ALU did not take the slot.
- Writes to register 0 are dropped, and reg_write is never asserted for write_reg=0.
  - ALU with alu_dest=0 consumes no slot; the FIFO head may drain that cycle.
  - A FIFO head with dest=0 is popped silently: reg_write=0 next cycle, scoreboard untouched.
- FIFO:
  - lsu_ready = (fifo_count != FIFO_DEPTH), computed from current occupancy only; a same-cycle pop does not raise it.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Entries drain in strict arrival order.
  - Minimum LSU latency is 2 cycles: pushed at edge N, selected during cycle N+1, reg_write high in cycle N+2.
- Scoreboard:
  - issue_valid with issue_dest!=0 sets busy_mask[issue_dest] at the next edge.
  - Popping a FIFO entry with dest!=0 clears its bit at the same edge that registers the write.
  - Set and clear of the same bit in the same cycle: set wins, bit stays 1.
  - busy_mask[0] is constant 0.
  - ALU writes never touch the scoreboard.
- Decode guarantees no ALU write targets a busy register. Behaviour is undefined if it does; no checking is required.

Test Plan:
- Reset, then alu_valid=1, alu_dest=8, alu_data=0x00001234 for one cycle -> next cycle reg_write=1, write_reg=8, write_data=0x00001234; the following cycle reg_write=0.
- issue dest 5, then 3 cycles later push LSU dest 5, data 0xDEADBEEF with ALU idle -> busy_mask[5]=1 from the cycle after issue; reg_write=1, write_reg=5, write_data=0xDEADBEEF two cycles after the push; busy_mask[5]=0 in that same cycle.
- FIFO_DEPTH=4: alu_valid high with nonzero dests for 6 cycles while the LSU offers 5 results back-to-back -> lsu_ready falls after 4 accepts and fifo_count=4; 6 ALU writes appear first; then LSU entries 1..4 drain in order, and entry 5 is accepted once lsu_ready rises.
- FIFO holds 1 entry (dest 9, 0xCAFE0001) while alu_valid=1, alu_dest=0 -> next cycle reg_write=1, write_reg=9, write_data=0xCAFE0001; no write to register 0 ever observed.
- busy_mask[7]=1, FIFO head dest 7 pops in the same cycle that issue_valid=1, issue_dest=7 -> the write to 7 occurs and busy_mask[7] remains 1.
- 3 entries buffered, busy bits 3/4/6 set, reset pulsed one cycle -> next cycle fifo_count=0, busy_mask=0, reg_write=0; no further writes in the 10 cycles after reset.
